// File: rtl/main_mem_grant_arbiter.sv
// Registered round-robin owner arbiter for the shared main-memory port.
// Holds the grant while the owner keeps requesting, preempts after MAX_HOLD cycles under contention.
module main_mem_grant_arbiter #(
    parameter int N_REQ    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [N_REQ-1:0]                         req,
    output logic [N_REQ-1:0]                         grant,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id,
    output logic                                     busy,
    output logic                                     preempt
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0] ID_LAST   = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            state_r;
    logic [ID_W-1:0]   ptr_r;
    logic [HC_W-1:0]   hold_cnt_r;
    logic [N_REQ-1:0]  grant_r;
    logic [ID_W-1:0]   grant_id_r;
    logic              busy_r;
    logic              preempt_r;

    logic              found_s;
    logic [ID_W-1:0]   winner_s;
    logic              owner_req_s;
    logic              others_s;
    logic              timeout_s;

    function automatic logic [N_REQ-1:0] to_onehot(input logic [ID_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = {N_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
        logic [ID_W-1:0] n;
        if (idx == ID_LAST) begin
            n = {ID_W{1'b0}};
        end else begin
            n = idx + {{(ID_W-1){1'b0}}, 1'b1};
        end
        return n;
    endfunction

    // Priority search starting at ptr_r, wrapping modulo N_REQ.
    always_comb begin
        int sum;
        found_s  = 1'b0;
        winner_s = {ID_W{1'b0}};
        sum      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = int'(ptr_r) + i;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end else begin
                sum = sum;
            end
            if (!found_s && req[sum[ID_W-1:0]]) begin
                found_s  = 1'b1;
                winner_s = sum[ID_W-1:0];
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Owner status: is it still requesting, is anyone else waiting, has its hold run out.
    always_comb begin
        owner_req_s = req[grant_id_r];
        others_s    = |(req & ~grant_r);
        timeout_s   = (hold_cnt_r == HOLD_LAST);
    end

    // Arbiter FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {ID_W{1'b0}};
            hold_cnt_r <= {HC_W{1'b0}};
            grant_r    <= {N_REQ{1'b0}};
            grant_id_r <= {ID_W{1'b0}};
            busy_r     <= 1'b0;
            preempt_r  <= 1'b0;
        end else begin
            preempt_r <= 1'b0;
            case (state_r)
                // GAP arbitrates directly so a waiting core loses only the one dead cycle.
                ST_IDLE, ST_GAP: begin
                    hold_cnt_r <= {HC_W{1'b0}};
                    if (found_s) begin
                        grant_r    <= to_onehot(winner_s);
                        grant_id_r <= winner_s;
                        busy_r     <= 1'b1;
                        state_r    <= ST_OWN;
                    end else begin
                        grant_r    <= {N_REQ{1'b0}};
                        grant_id_r <= {ID_W{1'b0}};
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_OWN: begin
                    if (!owner_req_s || (timeout_s && others_s)) begin
                        // A release on the timeout edge is a plain release, not a preemption.
                        preempt_r  <= owner_req_s;
                        grant_r    <= {N_REQ{1'b0}};
                        grant_id_r <= {ID_W{1'b0}};
                        busy_r     <= 1'b0;
                        ptr_r      <= next_idx(grant_id_r);
                        hold_cnt_r <= {HC_W{1'b0}};
                        state_r    <= ST_GAP;
                    end else begin
                        if (timeout_s) begin
                            hold_cnt_r <= hold_cnt_r;
                        end else begin
                            hold_cnt_r <= hold_cnt_r + {{(HC_W-1){1'b0}}, 1'b1};
                        end
                        state_r <= ST_OWN;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ptr_r      <= {ID_W{1'b0}};
                    hold_cnt_r <= {HC_W{1'b0}};
                    grant_r    <= {N_REQ{1'b0}};
                    grant_id_r <= {ID_W{1'b0}};
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign grant    = grant_r;
    assign grant_id = grant_id_r;
    assign busy     = busy_r;
    assign preempt  = preempt_r;

endmodule

// File: tb/tb_main_mem_grant_arbiter.sv
// Directed bench for main_mem_grant_arbiter with MAX_HOLD=4 and three requesters.
module tb_main_mem_grant_arbiter;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       preempt;

    int n_total;
    int n_pass;

    main_mem_grant_arbiter #(.N_REQ(3), .MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .preempt  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One rising edge, then settle on the falling edge for sampling and driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] oh;
        n_total = 0;
        n_pass  = 0;
        rst = 1'b0;
        req = 3'b111;
        step();
        step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_id", 32'(grant_id), 32'h0);
        chk("rst_preempt", 32'(preempt), 32'h0);

        // Rotation under full contention.
        rst = 1'b1;
        step();
        for (int r = 0; r < 3; r++) begin
            oh = 3'b001 << r;
            for (int c = 0; c < 4; c++) begin
                chk("rot_grant", 32'(grant), 32'(oh));
                chk("rot_id", 32'(grant_id), 32'(r));
                chk("rot_no_preempt", 32'(preempt), 32'h0);
                step();
            end
            chk("rot_gap_grant", 32'(grant), 32'h0);
            chk("rot_gap_busy", 32'(busy), 32'h0);
            chk("rot_gap_preempt", 32'(preempt), 32'h1);
            step();
        end
        chk("rot_wrap_grant", 32'(grant), 32'h1);

        // Full release to IDLE.
        req = 3'b000;
        step();
        chk("rel_gap_grant", 32'(grant), 32'h0);
        chk("rel_gap_preempt", 32'(preempt), 32'h0);
        step();
        chk("idle_grant", 32'(grant), 32'h0);

        // Single requester holds past MAX_HOLD.
        req = 3'b100;
        for (int c = 0; c < 40; c++) begin
            step();
            chk("hold_grant", 32'(grant), 32'h4);
            chk("hold_preempt", 32'(preempt), 32'h0);
        end
        req = 3'b000;
        step();
        chk("hold_drop_grant", 32'(grant), 32'h0);
        chk("hold_drop_preempt", 32'(preempt), 32'h0);
        step();
        chk("hold_idle1", 32'(grant), 32'h0);
        step();
        chk("hold_idle2", 32'(grant), 32'h0);

        // Release and handoff to control tower.
        req = 3'b001;
        step();
        chk("ho_c1_grant", 32'(grant), 32'h1);
        req = 3'b011;
        step();
        chk("ho_c2_grant", 32'(grant), 32'h1);
        req = 3'b010;
        step();
        chk("ho_c3_grant", 32'(grant), 32'h0);
        chk("ho_c3_preempt", 32'(preempt), 32'h0);
        step();
        chk("ho_c4_grant", 32'(grant), 32'h2);
        chk("ho_c4_id", 32'(grant_id), 32'h1);

        // Release coinciding with the timeout edge.
        req = 3'b111;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("co_hold_grant", 32'(grant), 32'h2);
        end
        req = 3'b101;
        step();
        chk("co_gap_grant", 32'(grant), 32'h0);
        chk("co_gap_preempt", 32'(preempt), 32'h0);
        step();
        chk("co_next_grant", 32'(grant), 32'h4);
        chk("co_next_id", 32'(grant_id), 32'h2);

        // Move ptr to 1 with control tower owning, then reset mid-grant.
        req = 3'b001;
        step();
        chk("pre_gap1", 32'(grant), 32'h0);
        step();
        chk("pre_own0", 32'(grant), 32'h1);
        req = 3'b010;
        step();
        chk("pre_gap2", 32'(grant), 32'h0);
        step();
        chk("pre_own1", 32'(grant), 32'h2);
        chk("pre_own1_busy", 32'(busy), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_id", 32'(grant_id), 32'h0);
        chk("mid_rst_preempt", 32'(preempt), 32'h0);
        step();
        req = 3'b011;
        rst = 1'b1;
        step();
        chk("post_rst_grant", 32'(grant), 32'h1);
        chk("post_rst_id", 32'(grant_id), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/main_mem_grant_arbiter.md
# main_mem_grant_arbiter

Registered round-robin arbiter that decides which core (codemaker, control tower, agent 1) owns the shared main-memory port. It replaces the combinational grant source feeding the main-memory grant mux. It adds four things: grant hold while the owner keeps requesting, a bounded hold time with preemption, a one-cycle dead gap between owners, and an owner index for the mux. It sits between the per-core memory controllers' `main_mem_req` outputs and the main-memory mux.

## Interface
- `N_REQ`, default 3: number of requesters (`NUMBER_OF_AGENTS+2`). Bit 2 is codemaker, bit 1 is control tower, bit 0 is agent 1.
- `MAX_HOLD`, default 16: maximum consecutive granted cycles before the owner can be preempted. Must be ≥2.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req` in `N_REQ`: per-core main-memory request, level-held for the whole access.
- `grant` out `N_REQ`: registered, one-hot or zero. This is the mux select.
- `grant_id` out `$clog2(N_REQ)`: index of the current owner. Valid only while `busy`=1, otherwise 0.
- `busy` out 1: high while any grant bit is high.
- `preempt` out 1: one-cycle pulse on the edge a grant is revoked by timeout.

## Operation
- **State machine** with three states: IDLE, OWN and GAP.
- **Round-robin pointer `ptr`** (reset 0). Priority order is `ptr`, `ptr+1`, …, wrapping modulo `N_REQ`.
- **IDLE**
  - `req`==0: stay in IDLE.
  - Otherwise, the first set bit in priority order wins. Next edge: `grant`=onehot(winner), `grant_id`=winner, state→OWN, `hold_cnt`=0.
- **OWN**
  - `hold_cnt` increments each cycle and saturates at `MAX_HOLD-1`.
  - Normal release: the owner's `req`=0. Next edge: `grant`=0, state→GAP, `ptr`=owner+1 (mod `N_REQ`).
  - Preemption: `hold_cnt`==`MAX_HOLD-1`, the owner's `req`=1, and any other `req` bit is 1. Next edge: `grant`=0, `preempt`=1 for one cycle, state→GAP, `ptr`=owner+1.
  - `hold_cnt` saturated with no other requester: the owner keeps the grant indefinitely and no preempt occurs.
- **GAP**
  - Lasts exactly one cycle with `grant`=0, so two cores never drive the mux on adjacent cycles.
  - Next state is IDLE. Arbitration happens in IDLE, so the next grant follows IDLE evaluation.
  - The GAP→IDLE→grant path takes two edges. An implementation may merge the IDLE evaluation into GAP (GAP arbitrates directly) to save one cycle. The team's decision: GAP arbitrates directly. If `req`≠0 during GAP, the next edge issues the new grant and enters OWN; otherwise it enters IDLE.
- **Preempted owner** keeps `req` high and competes again at the lowest priority.
- **Invariant:** at most one `grant` bit is ever high.
- **Reset (`rst`=0) at any time**, including mid-grant:
  - Immediately: `grant`=0, `grant_id`=0, `busy`=0, `preempt`=0.
  - State=IDLE, `ptr`=0, `hold_cnt`=0.

## Timing
- Request to grant latency from IDLE: `req` is sampled at edge k, and `grant` is high after edge k (visible in cycle k+1).
- Release: the owner drops `req` before edge t. After edge t, `grant`=0 (GAP). The earliest next grant is after edge t+1.
- Maximum contiguous ownership under contention is `MAX_HOLD` cycles, followed by a 1-cycle gap.
- Worst-case wait for a requester under continuous contention is (`N_REQ`-1)·(`MAX_HOLD`+1) cycles.
- Simultaneous events at one edge:
  - Owner `req` drop coinciding with the timeout condition: treated as a normal release, `preempt`=0.
  - Multiple new requests: resolved only by priority order from `ptr`.
  - A `req` raised and dropped within a cycle it is not sampled: ignored.
- `preempt` is high only during the cycle following the revoking edge, aligned with GAP.
- All outputs are registered. There is no combinational path from `req` to `grant`.

## Test plan
- **Reset values:** assert `rst`=0 with `req`=3'b111 → `grant`=0, `busy`=0, `grant_id`=0. Release reset → after the first edge, `grant`=3'b001 (`ptr`=0 wins).
- **Rotation:** `req`=3'b111 held, `MAX_HOLD`=4. Grants go 001 for 4 cycles, gap, 010 for 4 cycles, gap, 100 for 4 cycles, gap, 001. `preempt` pulses 3 times.
- **Hold without contention:** `req`=3'b100 only, for 40 cycles → `grant`=100 continuously, `preempt` never 1. Drop `req` → next cycle `grant`=0, then stays 0.
- **Release and handoff:** agent 1 owns, control tower is requesting, agent 1 drops `req` at cycle 2 → cycle 3 `grant`=0, cycle 4 `grant`=010, `grant_id`=1.
- **Coincident release and timeout:** owner drops `req` exactly when `hold_cnt`=`MAX_HOLD-1` with others requesting → GAP occurs with `preempt`=0.
- **Mid-grant reset:** `grant`=010, pulse `rst` low between edges → `grant`=0 immediately, with no edge required. After release, arbitration restarts from `ptr`=0.
